// File: rtl/caesar_sequencer.sv
// Sequencer for the combinational Caesar datapath: owns the plaintext
// counter and committed key/mode, then captures and range-checks results.
module caesar_sequencer #(
    parameter int MOD    = 26,
    parameter int DATA_W = 6,
    parameter int KEY_W  = 5,
    parameter int PASS_W = 8
) (
    input  logic              CLOCK_50,
    input  logic              rst,
    input  logic              tick,
    input  logic              start,
    input  logic              step,
    input  logic [KEY_W-1:0]  key_in,
    input  logic              mode_in,
    input  logic [DATA_W-1:0] res_in,
    output logic [DATA_W-1:0] pt_out,
    output logic [DATA_W-1:0] key_out,
    output logic              mode_out,
    output logic [DATA_W-1:0] res_out,
    output logic              res_valid,
    output logic [PASS_W-1:0] pass_cnt,
    output logic              overrun,
    output logic              err
);

    localparam logic [DATA_W-1:0] LAST = DATA_W'(MOD - 1);

    typedef enum logic [2:0] {
        IDLE,
        APPLY,
        ISSUE,
        CAPTURE,
        WAIT
    } state_t;

    state_t state;
    state_t next_state;

    logic [DATA_W-1:0] key_ext;
    logic [DATA_W-1:0] key_c;
    logic              adv_ev;
    logic              adv;
    logic              apply_en;
    logic              cap_en;
    logic              ovr_set;
    logic              busy;

    // Captured result is staged one cycle before it reaches the outputs
    logic              cap_pend;
    logic              cap_bad;
    logic [DATA_W-1:0] cap_data;

    assign key_ext = DATA_W'(key_in);
    assign key_c   = (key_ext > LAST) ? LAST : key_ext;
    assign adv_ev  = (start & tick) | (~start & step);
    assign busy    = (state == APPLY) || (state == ISSUE) ||
                     (state == CAPTURE);
    assign ovr_set = start & tick & busy;

    always_ff @(posedge CLOCK_50 or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        adv        = 1'b0;
        apply_en   = 1'b0;
        cap_en     = 1'b0;
        unique case (state)
            IDLE: begin
                if (start || step) begin
                    next_state = APPLY;
                end
            end
            APPLY: begin
                apply_en   = 1'b1;
                next_state = ISSUE;
            end
            ISSUE: begin
                next_state = CAPTURE;
            end
            CAPTURE: begin
                cap_en     = 1'b1;
                next_state = WAIT;
            end
            WAIT: begin
                if (adv_ev) begin
                    adv = 1'b1;
                    if (key_c != key_out || mode_in != mode_out) begin
                        next_state = APPLY;
                    end else begin
                        next_state = ISSUE;
                    end
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge rst) begin
        if (!rst) begin
            pt_out    <= '0;
            key_out   <= '0;
            mode_out  <= 1'b0;
            res_out   <= '0;
            res_valid <= 1'b0;
            pass_cnt  <= '0;
            overrun   <= 1'b0;
            err       <= 1'b0;
            cap_pend  <= 1'b0;
            cap_bad   <= 1'b0;
            cap_data  <= '0;
        end else begin
            cap_pend  <= cap_en;
            res_valid <= cap_pend;
            if (cap_en) begin
                cap_bad  <= (res_in > LAST);
                cap_data <= (res_in > LAST) ? '0 : res_in;
            end
            if (cap_pend) begin
                res_out <= cap_data;
                if (cap_bad) begin
                    err <= 1'b1;
                end
            end
            if (apply_en) begin
                key_out  <= key_c;
                mode_out <= mode_in;
            end
            if (adv) begin
                if (pt_out == LAST) begin
                    pt_out   <= '0;
                    pass_cnt <= pass_cnt + PASS_W'(1);
                end else begin
                    pt_out <= pt_out + DATA_W'(1);
                end
            end
            if (ovr_set) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_caesar_sequencer.sv
// Bench for caesar_sequencer: directed stimulus, queued expectations,
// and a monitor that checks every res_valid pulse and its timing.
module tb_caesar_sequencer;

    logic       clk;
    logic       rst;
    logic       tick;
    logic       start;
    logic       step;
    logic [4:0] key_in;
    logic       mode_in;
    logic [5:0] res_in;
    logic [5:0] pt_out;
    logic [5:0] key_out;
    logic       mode_out;
    logic [5:0] res_out;
    logic       res_valid;
    logic [7:0] pass_cnt;
    logic       overrun;
    logic       err;

    logic       force_bad;
    int         mdl_s;
    int         cyc;
    int         n_chk;
    int         n_fail;

    typedef struct {
        logic [5:0] res;
        logic [5:0] pt;
        logic [5:0] key;
        logic       mode;
        logic       err;
        int         at;
    } exp_t;

    exp_t exp_q[$];

    caesar_sequencer dut (
        .CLOCK_50  (clk),
        .rst       (rst),
        .tick      (tick),
        .start     (start),
        .step      (step),
        .key_in    (key_in),
        .mode_in   (mode_in),
        .res_in    (res_in),
        .pt_out    (pt_out),
        .key_out   (key_out),
        .mode_out  (mode_out),
        .res_out   (res_out),
        .res_valid (res_valid),
        .pass_cnt  (pass_cnt),
        .overrun   (overrun),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Combinational cipher stand-in driven from the committed operands
    always_comb begin
        if (mode_out) begin
            mdl_s = int'(pt_out) + 26 - int'(key_out);
        end else begin
            mdl_s = int'(pt_out) + int'(key_out);
        end
        res_in = force_bad ? 6'd40 : 6'(mdl_s % 26);
    end

    task automatic chk(input string name, input int act, input int req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (rst && res_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("valid_cycle", cyc, e.at);
                chk("res_out", int'(res_out), int'(e.res));
                chk("pt_out", int'(pt_out), int'(e.pt));
                chk("key_out", int'(key_out), int'(e.key));
                chk("mode_out", int'(mode_out), int'(e.mode));
                chk("err", int'(err), int'(e.err));
            end
        end else if (exp_q.size() != 0 && exp_q[0].at < cyc) begin
            chk("missing_valid", cyc, exp_q[0].at);
            void'(exp_q.pop_front());
        end
    end

    task automatic adv(input logic t, input logic s,
                       input logic [5:0] r, input logic [5:0] p,
                       input logic [5:0] k, input logic m,
                       input logic e, input int lat);
        exp_t x;
        @(negedge clk);
        tick = t;
        step = s;
        x = '{r, p, k, m, e, cyc + lat};
        exp_q.push_back(x);
        @(negedge clk);
        tick = 1'b0;
        step = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_pt"}, int'(pt_out), 0);
        chk({tag, "_key"}, int'(key_out), 0);
        chk({tag, "_mode"}, int'(mode_out), 0);
        chk({tag, "_res"}, int'(res_out), 0);
        chk({tag, "_valid"}, int'(res_valid), 0);
        chk({tag, "_pass"}, int'(pass_cnt), 0);
        chk({tag, "_ovr"}, int'(overrun), 0);
        chk({tag, "_err"}, int'(err), 0);
    endtask

    initial begin
        exp_t x;
        n_chk     = 0;
        n_fail    = 0;
        rst       = 1'b0;
        tick      = 1'b0;
        start     = 1'b0;
        step      = 1'b0;
        key_in    = 5'd3;
        mode_in   = 1'b0;
        force_bad = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_pt", int'(pt_out), 0);

        // Free-run start: first result goes through APPLY
        @(negedge clk);
        start = 1'b1;
        x = '{6'd3, 6'd0, 6'd3, 1'b0, 1'b0, cyc + 5};
        exp_q.push_back(x);
        repeat (8) @(negedge clk);

        adv(1, 0, 6'd4, 6'd1, 6'd3, 1'b0, 1'b0, 4);

        // Key change waits for the next advance
        key_in = 5'd7;
        repeat (3) @(negedge clk);
        chk("key_hold", int'(key_out), 3);
        adv(1, 0, 6'd9, 6'd2, 6'd7, 1'b0, 1'b0, 5);

        key_in = 5'd31;
        adv(1, 0, 6'd2, 6'd3, 6'd25, 1'b0, 1'b0, 5);

        // Decrypt with key 25 up to the wrap
        key_in  = 5'd25;
        mode_in = 1'b1;
        for (int p = 4; p <= 25; p++) begin
            adv(1, 0, 6'((p + 1) % 26), 6'(p), 6'd25, 1'b1, 1'b0,
                (p == 4) ? 5 : 4);
        end
        chk("pass_before_wrap", int'(pass_cnt), 0);
        adv(1, 0, 6'd1, 6'd0, 6'd25, 1'b1, 1'b0, 4);
        chk("pass_wrap", int'(pass_cnt), 1);
        chk("pt_wrap", int'(pt_out), 0);

        // Paused: ticks ignored, step advances, tick+step once
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tick = 1'b1;
            @(negedge clk);
            tick = 1'b0;
        end
        repeat (4) @(negedge clk);
        chk("pause_pt", int'(pt_out), 0);
        adv(0, 1, 6'd2, 6'd1, 6'd25, 1'b1, 1'b0, 4);
        adv(1, 1, 6'd3, 6'd2, 6'd25, 1'b1, 1'b0, 4);
        chk("tick_step_pt", int'(pt_out), 2);
        chk("no_overrun_yet", int'(overrun), 0);

        // Back-to-back ticks: second lands in ISSUE
        @(negedge clk);
        start = 1'b1;
        tick  = 1'b1;
        x = '{6'd4, 6'd3, 6'd25, 1'b1, 1'b0, cyc + 4};
        exp_q.push_back(x);
        @(negedge clk);
        @(negedge clk);
        tick = 1'b0;
        repeat (6) @(negedge clk);
        chk("overrun", int'(overrun), 1);
        chk("overrun_pt", int'(pt_out), 3);

        // Out-of-range cipher result
        force_bad = 1'b1;
        adv(1, 0, 6'd0, 6'd4, 6'd25, 1'b1, 1'b1, 4);
        force_bad = 1'b0;
        chk("err_sticky", int'(err), 1);
        chk("bad_res", int'(res_out), 0);

        // Reset while in CAPTURE
        @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        chk("pre_rst_pt", int'(pt_out), 5);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_all_zero("rst_capture");
        @(negedge clk);
        chk("rst_valid_1", int'(res_valid), 0);
        @(negedge clk);
        chk("rst_valid_2", int'(res_valid), 0);
        start = 1'b0;
        rst   = 1'b1;
        repeat (4) @(negedge clk);
        chk("end_valid", int'(res_valid), 0);
        chk("queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
